// File: rtl/arp_cache_assoc.sv
// N-way set-associative key->value cache, CRC-32 set index, round-robin victim per set.
// Query: 2-stage pipeline, one per cycle, response held until consumed; learn commits the cycle after capture.
`timescale 1ns/1ps
module arp_cache_assoc #(
  parameter int CACHE_ADDR_WIDTH = 6,
  parameter int WAYS             = 4,
  parameter int KEY_WIDTH        = 32,
  parameter int VALUE_WIDTH      = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   query_request_valid,
  output logic                   query_request_ready,
  input  logic [KEY_WIDTH-1:0]   query_request_ip,
  output logic                   query_response_valid,
  input  logic                   query_response_ready,
  output logic                   query_response_error,
  output logic [VALUE_WIDTH-1:0] query_response_mac,
  input  logic                   write_request_valid,
  output logic                   write_request_ready,
  input  logic [KEY_WIDTH-1:0]   write_request_ip,
  input  logic [VALUE_WIDTH-1:0] write_request_mac,
  input  logic                   clear_cache,
  output logic                   clear_busy
);

  localparam int SETS = 2 ** CACHE_ADDR_WIDTH;
  localparam int IW   = CACHE_ADDR_WIDTH;
  localparam int VB   = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), init all ones, no final XOR.
  function automatic logic [IW-1:0] crc_index(input logic [KEY_WIDTH-1:0] key);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      c = (c[0] ^ key[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c[IW-1:0];
  endfunction

  logic [WAYS-1:0]        valid_mem [SETS];
  logic [KEY_WIDTH-1:0]   key_mem   [SETS][WAYS];
  logic [VALUE_WIDTH-1:0] val_mem   [SETS][WAYS];
  logic [VB-1:0]          vptr_mem  [SETS];

  logic [IW-1:0] sweep_idx;

  always_ff @(posedge clk) begin
    if (rst || clear_cache) begin
      clear_busy <= 1'b1;
      sweep_idx  <= '0;
    end else if (clear_busy) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (&sweep_idx) clear_busy <= 1'b0;
    end
  end

  // ---------------- query pipeline ----------------
  logic                   lk_vld;
  logic [KEY_WIDTH-1:0]   lk_key;
  logic [IW-1:0]          lk_idx;
  logic                   lk_adv;
  logic                   q_acc;
  logic [WAYS-1:0]        q_hit;
  logic [VALUE_WIDTH-1:0] q_mac;

  assign lk_adv              = !query_response_valid || query_response_ready;
  assign query_request_ready = !clear_busy && (!lk_vld || lk_adv);
  assign q_acc               = query_request_valid && query_request_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_vld <= 1'b0;
      lk_key <= '0;
      lk_idx <= '0;
    end else if (q_acc) begin
      lk_vld <= 1'b1;
      lk_key <= query_request_ip;
      lk_idx <= crc_index(query_request_ip);
    end else if (lk_adv) begin
      lk_vld <= 1'b0;
    end
  end

  // The write path never lets a key occupy two ways, so OR-ing hit values is a plain mux.
  always_comb begin
    q_hit = '0;
    q_mac = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[lk_idx][w] && key_mem[lk_idx][w] == lk_key) begin
        q_hit[w] = 1'b1;
        q_mac    = q_mac | val_mem[lk_idx][w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      query_response_valid <= 1'b0;
      query_response_error <= 1'b0;
      query_response_mac   <= '0;
    end else if (lk_vld && lk_adv) begin
      query_response_valid <= 1'b1;
      query_response_error <= ~|q_hit;
      query_response_mac   <= q_mac;
    end else if (query_response_ready) begin
      query_response_valid <= 1'b0;
    end
  end

  // ---------------- learn path ----------------
  logic                   wr_vld;
  logic [KEY_WIDTH-1:0]   wr_key;
  logic [VALUE_WIDTH-1:0] wr_val;
  logic [IW-1:0]          wr_idx;
  logic                   w_acc;
  logic                   commit;
  logic [WAYS-1:0]        w_match;
  logic [WAYS-1:0]        w_inv;
  logic [WAYS-1:0]        sel;
  logic                   bump;
  logic                   found;

  assign write_request_ready = !clear_busy;
  assign w_acc               = write_request_valid && write_request_ready;
  assign commit              = wr_vld && !clear_cache && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld <= 1'b0;
      wr_key <= '0;
      wr_val <= '0;
      wr_idx <= '0;
    end else begin
      wr_vld <= w_acc && !clear_cache;
      if (w_acc) begin
        wr_key <= write_request_ip;
        wr_val <= write_request_mac;
        wr_idx <= crc_index(write_request_ip);
      end
    end
  end

  always_comb begin
    w_match = '0;
    w_inv   = '0;
    sel     = '0;
    bump    = 1'b0;
    found   = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      w_inv[w]   = !valid_mem[wr_idx][w];
      w_match[w] = valid_mem[wr_idx][w] && key_mem[wr_idx][w] == wr_key;
    end
    if (|w_match) begin
      sel = w_match;
    end else if (|w_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w_inv[w] && !found) begin
          sel[w] = 1'b1;
          found  = 1'b1;
        end
      end
    end else begin
      for (int w = 0; w < WAYS; w++) sel[w] = (vptr_mem[wr_idx] == VB'(w));
      bump = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_busy) begin
      valid_mem[sweep_idx] <= '0;
      vptr_mem[sweep_idx]  <= '0;
    end else if (commit) begin
      for (int w = 0; w < WAYS; w++) begin
        if (sel[w]) begin
          valid_mem[wr_idx][w] <= 1'b1;
          key_mem[wr_idx][w]   <= wr_key;
          val_mem[wr_idx][w]   <= wr_val;
        end
      end
      if (bump) vptr_mem[wr_idx] <= (WAYS > 1) ? vptr_mem[wr_idx] + 1'b1 : '0;
    end
  end

endmodule
